// File: rtl/bitwise_logic_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready handshake and a
// running XOR accumulator. Results carry zero/all-ones flags.
module bitwise_logic_pipe #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inValid,
    output logic             inReady,
    input  logic [2:0]       opCode,
    input  logic [WIDTH-1:0] inputA,
    input  logic [WIDTH-1:0] inputB,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] outputC,
    output logic             zeroFlag,
    output logic             onesFlag,
    output logic [WIDTH-1:0] accOut
);

    typedef enum logic [2:0] {
        OpAnd  = 3'b000,
        OpOr   = 3'b001,
        OpXor  = 3'b010,
        OpXnor = 3'b011,
        OpNand = 3'b100,
        OpNor  = 3'b101,
        OpNotA = 3'b110,
        OpAcc  = 3'b111
    } opKind_t;

    logic             s1Valid;
    opKind_t          s1Op;
    logic [WIDTH-1:0] s1A;
    logic [WIDTH-1:0] s1B;
    logic [WIDTH-1:0] acc;

    logic             s1Load;
    logic             s2Load;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] nextAcc;

    // S2 is free if empty or draining this cycle; S1 is free if empty or moving into S2.
    assign inReady = !reset && (!s1Valid || !outValid || outReady);
    assign s1Load  = inValid && inReady;
    assign s2Load  = s1Valid && (!outValid || outReady);

    always_comb begin
        result  = '0;
        nextAcc = acc;
        unique case (s1Op)
            OpAnd:  result = s1A & s1B;
            OpOr:   result = s1A | s1B;
            OpXor:  result = s1A ^ s1B;
            OpXnor: result = ~(s1A ^ s1B);
            OpNand: result = ~(s1A & s1B);
            OpNor:  result = ~(s1A | s1B);
            OpNotA: result = ~s1A;
            OpAcc: begin
                result  = acc ^ s1A;
                nextAcc = acc ^ s1A;
            end
            default: result = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1Valid <= 1'b0;
            s1Op    <= OpAnd;
            s1A     <= '0;
            s1B     <= '0;
        end else begin
            if (s1Load) begin
                s1Valid <= 1'b1;
                s1Op    <= opKind_t'(opCode);
                s1A     <= inputA;
                s1B     <= inputB;
            end else if (s2Load) begin
                s1Valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outValid <= 1'b0;
            outputC  <= '0;
            zeroFlag <= 1'b0;
            onesFlag <= 1'b0;
            accOut   <= '0;
            acc      <= '0;
        end else begin
            if (s2Load) begin
                outValid <= 1'b1;
                outputC  <= result;
                zeroFlag <= (result == '0);
                onesFlag <= (result == '1);
                accOut   <= nextAcc;
                acc      <= nextAcc;
            end else if (outReady) begin
                outValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Scoreboard bench for bitwise_logic_pipe: the driver queues expected results on
// acceptance, a negedge monitor pops and compares on each output transfer.
module tb_bitwise_logic_pipe;

    localparam int unsigned WIDTH = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             inValid;
    logic             inReady;
    logic [2:0]       opCode;
    logic [WIDTH-1:0] inputA;
    logic [WIDTH-1:0] inputB;
    logic             outValid;
    logic             outReady;
    logic [WIDTH-1:0] outputC;
    logic             zeroFlag;
    logic             onesFlag;
    logic [WIDTH-1:0] accOut;

    bitwise_logic_pipe #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .inValid  (inValid),
        .inReady  (inReady),
        .opCode   (opCode),
        .inputA   (inputA),
        .inputB   (inputB),
        .outValid (outValid),
        .outReady (outReady),
        .outputC  (outputC),
        .zeroFlag (zeroFlag),
        .onesFlag (onesFlag),
        .accOut   (accOut)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] c;
        logic [WIDTH-1:0] acc;
    } exp_t;

    exp_t             sb[$];
    exp_t             monExp;
    int               checks = 0;
    int               failures = 0;
    int               pops = 0;
    int               popRun = 0;
    int               lastPopCyc = -10;
    int               cyc = 0;
    int               stallCount = 0;
    logic [WIDTH-1:0] modelAcc;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: one comparison set per output transfer.
    always @(negedge clk) begin
        if (!reset && outValid && outReady) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got 0x%0h expected no output", outputC);
            end else begin
                monExp = sb.pop_front();
                chk("outputC", {48'd0, outputC}, {48'd0, monExp.c});
                chk("accOut", {48'd0, accOut}, {48'd0, monExp.acc});
                chk("zeroFlag", {63'd0, zeroFlag}, {63'd0, monExp.c == '0});
                chk("onesFlag", {63'd0, onesFlag}, {63'd0, monExp.c == '1});
                pops++;
                popRun = (lastPopCyc == cyc - 1) ? popRun + 1 : 1;
                lastPopCyc = cyc;
            end
        end
    end

    function automatic logic [WIDTH-1:0] model(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] accIn);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~(a ^ b);
            3'd4:    return ~(a & b);
            3'd5:    return ~(a | b);
            3'd6:    return ~a;
            default: return accIn ^ a;
        endcase
    endfunction

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] expC, input logic [WIDTH-1:0] expAcc);
        int waitCyc = 0;
        bit done = 1'b0;
        opCode  = op;
        inputA  = a;
        inputB  = b;
        inValid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (inReady) begin
                sb.push_back('{c: expC, acc: expAcc});
                done = 1'b1;
            end else begin
                stallCount++;
                waitCyc++;
            end
            @(posedge clk);
            #1;
            if (!done && waitCyc >= 50) begin
                checks++;
                failures++;
                $display("FAIL send_timeout: got inReady=0 for %0d cycles expected acceptance",
                         waitCyc);
                done = 1'b1;
            end
        end
        inValid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] c;
        int               pops0;

        reset    = 1'b1;
        inValid  = 1'b0;
        opCode   = 3'd0;
        inputA   = '0;
        inputB   = '0;
        outReady = 1'b1;
        modelAcc = '0;
        #1;
        chk("rst_outValid", {63'd0, outValid}, 64'd0);
        chk("rst_inReady", {63'd0, inReady}, 64'd0);
        chk("rst_outputC", {48'd0, outputC}, 64'd0);
        chk("rst_accOut", {48'd0, accOut}, 64'd0);
        chk("rst_flags", {62'd0, zeroFlag, onesFlag}, 64'd0);
        #11;
        reset = 1'b0;
        @(negedge clk);
        chk("inReady_after_reset", {63'd0, inReady}, 64'd1);
        @(posedge clk);
        #1;

        // XNOR and two-cycle latency
        send(3'b011, 16'h8001, 16'h0000, 16'h7FFE, 16'h0000);
        @(negedge clk);
        chk("latency_cycle1_outValid", {63'd0, outValid}, 64'd0);
        @(negedge clk);
        chk("latency_cycle2_outValid", {63'd0, outValid}, 64'd1);
        @(posedge clk);
        #1;

        // Flags
        send(3'b011, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000);
        send(3'b010, 16'h1234, 16'h1234, 16'h0000, 16'h0000);

        // Accumulator chain plus interleaved AND
        send(3'b111, 16'h00FF, 16'h0000, 16'h00FF, 16'h00FF);
        send(3'b111, 16'h0F0F, 16'hAAAA, 16'h0FF0, 16'h0FF0);
        send(3'b111, 16'h00FF, 16'h5555, 16'h0F0F, 16'h0F0F);
        send(3'b000, 16'hF0F0, 16'h0FF0, 16'h00F0, 16'h0F0F);
        idle(4);

        // Backpressure: only two transactions fit
        outReady = 1'b0;
        send(3'b000, 16'hFFFF, 16'h00FF, 16'h00FF, 16'h0F0F);
        send(3'b001, 16'h1200, 16'h0034, 16'h1234, 16'h0F0F);
        opCode  = 3'b100;
        inputA  = 16'hFFFF;
        inputB  = 16'hFFFF;
        inValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_inReady_low", {63'd0, inReady}, 64'd0);
            chk("bp_outValid_held", {63'd0, outValid}, 64'd1);
            chk("bp_outputC_stable", {48'd0, outputC}, 64'h00FF);
        end
        @(posedge clk);
        #1;
        outReady = 1'b1;
        send(3'b100, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0F0F);
        send(3'b101, 16'h0000, 16'h0000, 16'hFFFF, 16'h0F0F);
        send(3'b110, 16'h00FF, 16'h1234, 16'hFF00, 16'h0F0F);
        idle(5);
        chk("bp_drained", sb.size(), 64'd0);

        // Streaming against the reference model
        modelAcc   = 16'h0F0F;
        stallCount = 0;
        pops0      = pops;
        for (int i = 0; i < 100; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = 16'($urandom);
            b  = 16'($urandom);
            c  = model(op, a, b, modelAcc);
            if (op == 3'b111) modelAcc = c;
            send(op, a, b, c, modelAcc);
        end
        idle(4);
        chk("stream_stalls", stallCount, 64'd0);
        chk("stream_results", pops - pops0, 64'd100);
        chk("stream_back_to_back", popRun, 64'd100);

        // Reset mid-stream with both stages full
        reset = 1'b1;
        idle(1);
        sb.delete();
        reset = 1'b0;
        idle(1);
        outReady = 1'b0;
        send(3'b111, 16'h5A5A, 16'h0000, 16'h5A5A, 16'h5A5A);
        send(3'b000, 16'hFFFF, 16'h0F0F, 16'h0F0F, 16'h5A5A);
        @(negedge clk);
        chk("full_outValid", {63'd0, outValid}, 64'd1);
        chk("full_accOut", {48'd0, accOut}, 64'h5A5A);
        chk("full_inReady", {63'd0, inReady}, 64'd0);
        reset = 1'b1;
        #1;
        chk("midrst_outValid", {63'd0, outValid}, 64'd0);
        chk("midrst_accOut", {48'd0, accOut}, 64'd0);
        chk("midrst_outputC", {48'd0, outputC}, 64'd0);
        chk("midrst_inReady", {63'd0, inReady}, 64'd0);
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        reset    = 1'b0;
        outReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_reset_no_stale", {63'd0, outValid}, 64'd0);
        end
        @(posedge clk);
        #1;
        send(3'b111, 16'h0001, 16'hFFFF, 16'h0001, 16'h0001);
        idle(4);
        chk("final_drained", sb.size(), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
